// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between issuing units and the shared-ALU round-robin arbiter.
// The slave modport is the arbiter side; master is the requester/consumer side.
interface alu_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*3-1:0]      req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NUM_REQ requesters, 1-cycle registered result.
// Define ALU_ARB_STATS_EN to add saturating accepted-op and stall-cycle counters.
module alu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_rr_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]     stat_ops,
  output logic [15:0]     stat_stall
`endif
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned SH_W = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic              big;
    logic [SH_W-1:0]   sh;
    r   = '0;
    big = (32'(b) >= DATA_W);
    sh  = b[SH_W-1:0];
    unique case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = big ? '0 : (a << sh);
      3'b110: r = big ? '0 : (a >> sh);
      // Oversized arithmetic shift saturates to the sign fill.
      3'b111: r = big ? {DATA_W{a[DATA_W-1]}} : DATA_W'($signed(a) >>> sh);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     idx;
  logic                any_valid;
  logic                can_accept;
  logic                accept;
  logic [2:0]          op_sel;
  logic [DATA_W-1:0]   a_sel, b_sel;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = ID_W'((32'(ptr_q) + off) % NUM_REQ);
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid    = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  // rst_n gates ready so no handshake completes while reset is held.
  assign can_accept    = rst_n && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = any_valid && can_accept;
  assign bus.req_ready = grant & {NUM_REQ{can_accept}};

  assign op_sel = bus.req_op[3*gnt_idx +: 3];
  assign a_sel  = bus.req_a[DATA_W*gnt_idx +: DATA_W];
  assign b_sel  = bus.req_b[DATA_W*gnt_idx +: DATA_W];

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_f(op_sel, a_sel, b_sel);
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (accept && (stat_ops_q != 16'hFFFF)) begin
      stat_ops_d = stat_ops_q + 16'd1;
    end
    if (rsp_valid_q && !bus.rsp_ready && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (4 requesters, 8-bit data).
// Stats scenario is compiled in only when ALU_ARB_STATS_EN is defined.
module tb_alu_rr_arbiter;
  localparam logic [2:0] OpAdd = 3'b000, OpSub = 3'b001, OpAnd = 3'b010, OpOr = 3'b011;
  localparam logic [2:0] OpXor = 3'b100, OpSll = 3'b101, OpSrl = 3'b110, OpSra = 3'b111;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_stall;
  alu_rr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stat_ops  (stat_ops),
    .stat_stall(stat_stall)
  );
`else
  alu_rr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Valid requests held during reset must not be handshaken.
    bus.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b d=%h id=%0d, expected v=0 d=00 id=0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, expected 0000", bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    set_req(1, OpAdd, 8'h7F, 8'h01);
    bus.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_ready: got %b, expected 0010", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h80 || bus.rsp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b d=%h id=%0d, expected v=1 d=80 id=1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    @(posedge clk);
    #1;
    // Drained with no new accept: valid drops, payload holds.
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h80 || bus.rsp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b d=%h id=%0d, expected v=0 d=80 id=1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, OpAdd, 8'(i), 8'h10);
    bus.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_first_ready: got %b, expected 0001", bus.req_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4) ||
          bus.rsp_data !== 8'(k % 4 + 16)) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got v=%b id=%0d d=%h, expected v=1 id=%0d d=%h", k,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % 4, 8'(k % 4 + 16));
      end
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      n_checks++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b, expected %b", k, bus.req_ready, exp_rdy);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, OpSub, 8'h00, 8'h01);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hFF || bus.rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_first: got v=%b d=%h id=%0d, expected v=1 d=FF id=0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    bus.rsp_ready = 1'b0;
    set_req(1, OpAnd, 8'hF0, 8'h3C);
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hFF || bus.rsp_id !== 2'd0 ||
          bus.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h id=%0d rdy=%b, expected v=1 d=FF id=0 rdy=0000",
                 c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    // Pointer advanced past requester 0, so 1 wins over 0.
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_ptr: got %b, expected 0010", bus.req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h30 || bus.rsp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_next: got v=%b d=%h id=%0d, expected v=1 d=30 id=1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_wrap: got %b, expected 0001", bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_ops();
    logic [2:0] ops [10] = '{OpSll, OpSrl, OpSra, OpSra, OpSub, OpOr, OpXor, OpSrl, OpSll, OpSra};
    logic [7:0] as  [10] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h10, 8'hA0, 8'hFF, 8'h81, 8'hFF, 8'h70};
    logic [7:0] bs  [10] = '{8'h01, 8'h09, 8'h03, 8'h08, 8'h20, 8'h05, 8'h0F, 8'h01, 8'h08, 8'h09};
    logic [7:0] exp [10] = '{8'h02, 8'h00, 8'hF0, 8'hFF, 8'hF0, 8'hA5, 8'hF0, 8'h40, 8'h00, 8'h00};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_req(3, ops[k], as[k], bs[k]);
      bus.req_valid = 4'b1000;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp[k] || bus.rsp_id !== 2'd3) begin
        n_fail++;
        $display("FAIL op[%0d] op=%b a=%h b=%h: got v=%b d=%h id=%0d, expected v=1 d=%h id=3",
                 k, ops[k], as[k], bs[k], bus.rsp_valid, bus.rsp_data, bus.rsp_id, exp[k]);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    set_req(2, OpXor, 8'h5A, 8'h0F);
    bus.req_valid = 4'b0100;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_id !== 2'd0 ||
        bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrun_reset: got v=%b d=%h id=%0d rdy=%b, expected v=0 d=00 id=0 rdy=0000",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_req(0, OpAdd, 8'h01, 8'h01);
    bus.req_valid = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    n_checks++;
    if (stat_ops !== 16'd5 || stat_stall !== 16'd300) begin
      n_fail++;
      $display("FAIL stats_count: got ops=%0d stall=%0d, expected ops=5 stall=300",
               stat_ops, stat_stall);
    end
    repeat (65300) @(posedge clk);
    #1;
    n_checks++;
    if (stat_stall !== 16'hFFFF || stat_ops !== 16'd5) begin
      n_fail++;
      $display("FAIL stats_sat: got ops=%0d stall=%h, expected ops=5 stall=FFFF",
               stat_ops, stat_stall);
    end
    bus.rsp_ready = 1'b1;
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_ops();
    test_reset_midrun();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
